// File: rtl/send_queue_if.sv
// ---------------------------------------------------------------------------
// Module  : send_queue_if
// Purpose : GameControl push port and inter-board Request/Ack wire bundle.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface send_queue_if #(
  parameter int DATA_W = 6,
  parameter int FIELDS = 2,
  parameter int DEPTH  = 4
);
  logic                       ctrl_en;
  logic [FIELDS*DATA_W-1:0]   ctrl_msg;
  logic                       ctrl_ready;
  logic [$clog2(DEPTH):0]     q_count;
  logic                       Ack_in;
  logic                       Request_out;
  logic [DATA_W-1:0]          inter_data_out;
  logic                       tx_done;
  logic                       tx_err;

  modport master (
    output ctrl_en, ctrl_msg, Ack_in,
    input  ctrl_ready, q_count, Request_out, inter_data_out, tx_done, tx_err
  );

  modport slave (
    input  ctrl_en, ctrl_msg, Ack_in,
    output ctrl_ready, q_count, Request_out, inter_data_out, tx_done, tx_err
  );
endinterface

`default_nettype wire

// File: rtl/send_queue.sv
// ---------------------------------------------------------------------------
// Module  : send_queue
// Purpose : Queued multi-field message transmitter on a 4-phase Request/Ack
//           handshake with optional Ack-timeout abort.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module send_queue #(
  parameter int DATA_W  = 6,
  parameter int FIELDS  = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  input  wire logic     interboard_rst,
  send_queue_if.slave   bus
);

  localparam int          c_PTR_W  = $clog2(DEPTH);
  localparam int          c_MSG_W  = FIELDS * DATA_W;
  localparam int          c_IDX_W  = (FIELDS > 1) ? $clog2(FIELDS) : 1;
  localparam int          c_TCNT_W = $clog2(TIMEOUT + 2);
  localparam int unsigned c_TLIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(FIELDS - 1);
  localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_ACK_DN = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [c_MSG_W-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic [c_MSG_W-1:0]   r_shift;
  logic [DATA_W-1:0]    r_data;
  logic [c_IDX_W-1:0]   r_idx;
  logic [c_TCNT_W-1:0]  r_tcnt;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_advance;
  logic                 w_tmo;
  logic [c_MSG_W-1:0]   w_head;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_push  = bus.ctrl_en && !w_full;
  assign w_tmo   = (TIMEOUT > 0) && (r_tcnt == c_TCNT_W'(c_TLIM));
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.Ack_in)  w_next = S_ACK_DN;
        else if (w_tmo)  w_next = S_ERR;
      end
      S_ACK_DN: begin
        if (!bus.Ack_in) begin
          if (r_idx == c_LAST) begin
            w_next = S_DONE;
          end else begin
            w_advance = 1'b1;
            w_next    = S_REQ;
          end
        end else if (w_tmo) begin
          w_next = S_ERR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else if (interboard_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.ctrl_msg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_idx    <= '0;
      r_tcnt   <= '0;
    end else if (interboard_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_idx    <= '0;
      r_tcnt   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Fields leave LSB-first; the shifter holds the not-yet-sent remainder.
      if (w_pop) begin
        r_data  <= w_head[DATA_W-1:0];
        r_shift <= w_head >> DATA_W;
        r_idx   <= '0;
      end else if (w_advance) begin
        r_data  <= r_shift[DATA_W-1:0];
        r_shift <= r_shift >> DATA_W;
        r_idx   <= r_idx + 1'b1;
      end

      if (w_next != r_state) r_tcnt <= '0;
      else                   r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign bus.ctrl_ready     = !w_full;
  assign bus.q_count        = r_count;
  assign bus.Request_out    = (r_state == S_REQ);
  assign bus.inter_data_out = r_data;
  assign bus.tx_done        = (r_state == S_DONE);
  assign bus.tx_err         = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_send_queue.sv
// ---------------------------------------------------------------------------
// Module  : tb_send_queue
// Purpose : Self-checking bench for send_queue (FIELDS=2, DEPTH=4, TIMEOUT=8).
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_send_queue;

  localparam int DW = 6;
  localparam int NF = 2;
  localparam int DP = 4;
  localparam int TO = 8;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic irst = 1'b0;

  always #5 clk = ~clk;

  send_queue_if #(.DATA_W(DW), .FIELDS(NF), .DEPTH(DP)) bus ();

  send_queue #(.DATA_W(DW), .FIELDS(NF), .DEPTH(DP), .TIMEOUT(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (irst),
    .bus            (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] sb[$];

  int   ack_mode = 0;
  logic ack_man  = 1'b0;
  logic ack_auto = 1'b0;
  int   ack_dly  = 3;
  int   ack_cnt  = 0;
  assign bus.Ack_in = (ack_mode == 1) ? ack_auto : ack_man;

  int   n_rise = 0;
  int   n_done = 0;
  int   n_err  = 0;
  logic prev_req = 1'b0;

  typedef struct {
    logic              en;
    logic [NF*DW-1:0]  msg;
    logic              acc;
    int                q;
    logic              rdy;
    logic              req;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Wire monitor: every new Request pulse must carry the next expected field.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      if (bus.Request_out && !prev_req) begin
        n_rise++;
        if (sb.size() == 0) begin
          chk("unexpected_field", int'(bus.inter_data_out), -1);
        end else begin
          e = sb.pop_front();
          chk("wire_field", int'(bus.inter_data_out), int'(e));
        end
      end
      if (bus.tx_done) n_done++;
      if (bus.tx_err)  n_err++;
    end
    prev_req = bus.Request_out;
    if (ack_mode != 1) begin
      ack_auto = 1'b0;
      ack_cnt  = 0;
    end else if (bus.Request_out && !ack_auto) begin
      ack_cnt++;
      if (ack_cnt >= ack_dly) ack_auto = 1'b1;
    end else if (!bus.Request_out && ack_auto) begin
      ack_auto = 1'b0;
      ack_cnt  = 0;
    end
  end

  task automatic push(input logic [NF*DW-1:0] m);
    bus.ctrl_en  = 1'b1;
    bus.ctrl_msg = m;
    sb.push_back(m[DW-1:0]);
    sb.push_back(m[2*DW-1:DW]);
    @(negedge clk);
    bus.ctrl_en = 1'b0;
  endtask

  task automatic wait_req(input logic lvl);
    int t = 0;
    while (bus.Request_out != lvl && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("wait_request_level", int'(bus.Request_out), int'(lvl));
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 600) begin
      @(negedge clk);
      t++;
    end
    chk("tx_done_count", n_done, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q_count"},    int'(bus.q_count),        0);
    chk({tag, "_ctrl_ready"}, int'(bus.ctrl_ready),     1);
    chk({tag, "_request"},    int'(bus.Request_out),    0);
    chk({tag, "_data"},       int'(bus.inter_data_out), 0);
    chk({tag, "_tx_done"},    int'(bus.tx_done),        0);
    chk({tag, "_tx_err"},     int'(bus.tx_err),         0);
  endtask

  task automatic reach_ack_dn_field1();
    push({6'h1B, 6'h24});
    push({6'h3C, 6'h0F});
    wait_req(1'b1);
    ack_man = 1'b1;
    wait_req(1'b0);
    ack_man = 1'b0;
    wait_req(1'b1);
    ack_man = 1'b1;
    wait_req(1'b0);
  endtask

  initial begin
    int base;
    int hi;
    int t;
    logic [NF*DW-1:0] m;

    bus.ctrl_en  = 1'b0;
    bus.ctrl_msg = '0;

    tv[0] = '{1'b1, {6'd40, 6'd1}, 1'b1, 1, 1'b1, 1'b0};
    tv[1] = '{1'b1, {6'd41, 6'd2}, 1'b1, 1, 1'b1, 1'b1};
    tv[2] = '{1'b1, {6'd42, 6'd3}, 1'b1, 2, 1'b1, 1'b1};
    tv[3] = '{1'b1, {6'd43, 6'd4}, 1'b1, 3, 1'b1, 1'b1};
    tv[4] = '{1'b1, {6'd44, 6'd5}, 1'b1, 4, 1'b0, 1'b1};
    tv[5] = '{1'b1, {6'd45, 6'd6}, 1'b0, 4, 1'b0, 1'b1};
    tv[6] = '{1'b0, {6'd46, 6'd7}, 1'b0, 4, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);

    // Basic two-field message with a 3-cycle responder, plus first-request latency.
    ack_mode = 1;
    ack_dly  = 3;
    base = n_rise;
    push({6'h05, 6'h2A});
    chk("latency_req_low", int'(bus.Request_out), 0);
    @(negedge clk);
    chk("latency_req_high", int'(bus.Request_out), 1);
    wait_done(1);
    chk("t1_request_pulses", n_rise - base, 2);
    chk("t1_q_count", int'(bus.q_count), 0);

    // Fill the FIFO behind a stalled handshake; the 6th push must be refused.
    ack_mode = 0;
    ack_man  = 1'b0;
    base = n_done;
    for (int i = 0; i < 7; i++) begin
      bus.ctrl_en  = tv[i].en;
      bus.ctrl_msg = tv[i].msg;
      if (tv[i].en && tv[i].acc) begin
        sb.push_back(tv[i].msg[DW-1:0]);
        sb.push_back(tv[i].msg[2*DW-1:DW]);
      end
      @(negedge clk);
      chk($sformatf("t2_row%0d_q_count", i),    int'(bus.q_count),     tv[i].q);
      chk($sformatf("t2_row%0d_ctrl_ready", i), int'(bus.ctrl_ready),  int'(tv[i].rdy));
      chk($sformatf("t2_row%0d_request", i),    int'(bus.Request_out), int'(tv[i].req));
    end
    bus.ctrl_en = 1'b0;
    ack_mode = 1;
    ack_dly  = 1;
    wait_done(base + 5);
    chk("t2_sb_drained", sb.size(), 0);
    chk("t2_q_count", int'(bus.q_count), 0);

    // Ack stuck low: Request stays up exactly TIMEOUT cycles, then ERR.
    ack_mode = 0;
    ack_man  = 1'b0;
    base = n_done;
    bus.ctrl_en  = 1'b1;
    bus.ctrl_msg = {6'h31, 6'h13};
    sb.push_back(6'h13);
    @(negedge clk);
    bus.ctrl_en = 1'b0;
    push({6'h22, 6'h0A});
    wait_req(1'b1);
    hi = 0;
    while (bus.Request_out && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    chk("t3_request_high_cycles", hi, TO);
    chk("t3_tx_err_pulse", int'(bus.tx_err), 1);
    @(negedge clk);
    chk("t3_tx_err_cleared", int'(bus.tx_err), 0);
    ack_mode = 1;
    ack_dly  = 2;
    wait_done(base + 1);
    chk("t3_err_count", n_err, 1);
    chk("t3_sb_drained", sb.size(), 0);

    // Ack arrives in the final allowed REQ cycle: exit wins over timeout.
    ack_mode = 0;
    ack_man  = 1'b0;
    base = n_done;
    push({6'h2D, 6'h12});
    wait_req(1'b1);
    repeat (TO - 1) @(negedge clk);
    chk("t4_request_at_limit", int'(bus.Request_out), 1);
    ack_man = 1'b1;
    @(negedge clk);
    chk("t4_request_dropped", int'(bus.Request_out), 0);
    chk("t4_no_tx_err", int'(bus.tx_err), 0);
    ack_man = 1'b0;
    @(negedge clk);
    chk("t4_field1_request", int'(bus.Request_out), 1);
    ack_mode = 1;
    ack_dly  = 1;
    wait_done(base + 1);
    chk("t4_err_count", n_err, 1);

    // Simultaneous push and pop at count 3, then wrap the pointers.
    ack_mode = 0;
    ack_man  = 1'b0;
    base = n_done;
    for (int i = 0; i < 4; i++) push({6'(i + 20), 6'(i + 50)});
    chk("t5_pre_q_count", int'(bus.q_count), 3);
    ack_mode = 1;
    ack_dly  = 1;
    t = 0;
    while (!bus.tx_done && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("t5_first_done", int'(bus.tx_done), 1);
    @(negedge clk);
    chk("t5_idle_q_count", int'(bus.q_count), 3);
    push({6'h3F, 6'h15});
    chk("t5_push_pop_q_count", int'(bus.q_count), 3);
    chk("t5_push_pop_ready", int'(bus.ctrl_ready), 1);
    chk("t5_popped_request", int'(bus.Request_out), 1);
    for (int i = 5; i < 12; i++) begin
      t = 0;
      while (!bus.ctrl_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      m = NF*DW'($urandom);
      push(m);
    end
    wait_done(base + 12);
    chk("t5_sb_drained", sb.size(), 0);

    // Async reset mid-handshake drops everything in flight and queued.
    ack_mode = 0;
    ack_man  = 1'b0;
    reach_ack_dn_field1();
    chk("t6_pre_q_count", int'(bus.q_count), 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    sb.delete();
    ack_man = 1'b0;
    base = n_rise;
    hi = n_done;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_async_no_stale_request", n_rise - base, 0);
    chk("t6_async_no_stale_done", n_done - hi, 0);

    // Same again with the synchronous inter-board clear.
    reach_ack_dn_field1();
    irst    = 1'b1;
    ack_man = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_sync");
    irst = 1'b0;
    sb.delete();
    base = n_rise;
    hi = n_done;
    repeat (20) @(negedge clk);
    chk("t6_sync_no_stale_request", n_rise - base, 0);
    chk("t6_sync_no_stale_done", n_done - hi, 0);

    ack_mode = 1;
    ack_dly  = 2;
    push({6'h0C, 6'h33});
    wait_done(hi + 1);
    chk("t6_post_sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
